// File: rtl/writeback_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package writeback_pkg;

    localparam int P_NUM_REQS  = 4;
    localparam int P_NUM_REGS  = 32;
    localparam int P_DATA_BITS = 32;
    localparam int RF_ADDR_W   = $clog2(P_NUM_REGS);
    localparam int REQ_ID_W    = $clog2(P_NUM_REQS);

    typedef logic [RF_ADDR_W-1:0]   rf_addr_t;
    typedef logic [P_DATA_BITS-1:0] rf_data_t;
    typedef logic [REQ_ID_W-1:0]    req_id_t;

    // Writes to x0 are architecturally discarded, so they never need the port.
    localparam rf_addr_t RF_ZERO_ADDR = '0;

endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Round-robin (or fixed-priority when WRITEBACK_ARBITER_FIXED_PRIO_EN is defined)
// single-winner arbiter producing a one-hot grant and its index.
module rr_arbiter #(
    parameter int p_num_reqs = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [p_num_reqs-1:0]         req,
    input  logic                          en,
    output logic [p_num_reqs-1:0]         gnt,
    output logic [$clog2(p_num_reqs)-1:0] gnt_idx,
    output logic                          gnt_vld
);

    localparam int IW = $clog2(p_num_reqs);

`ifdef WRITEBACK_ARBITER_FIXED_PRIO_EN

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        if (en) begin
            for (int i = 0; i < p_num_reqs; i++) begin
                if (!gnt_vld && req[i]) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = IW'(i);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

`else

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    int            idx;

    // Search starts at ptr and wraps; the pointer moves just past the winner.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        ptr_d   = ptr_q;
        idx     = 0;
        if (en) begin
            for (int k = 0; k < p_num_reqs; k++) begin
                idx = (int'(ptr_q) + k) % p_num_reqs;
                if (!gnt_vld && req[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_idx  = IW'(idx);
                    gnt_vld  = 1'b1;
                end
            end
            if (gnt_vld) begin
                ptr_d = (gnt_idx == IW'(p_num_reqs - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/writeback_arbiter.sv
// Shares one register-file write port among several writeback units; x0 writes are
// acknowledged without arbitration. WRITEBACK_ARBITER_FIXED_PRIO_EN selects fixed priority.
module writeback_arbiter
    import writeback_pkg::*;
#(
    parameter int p_num_reqs  = 4,
    parameter int p_num_regs  = 32,
    parameter int p_data_bits = 32
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [p_num_reqs-1:0]                            req_val,
    output logic [p_num_reqs-1:0]                            req_rdy,
    input  logic [p_num_reqs-1:0][$clog2(p_num_regs)-1:0]    req_waddr,
    input  logic [p_num_reqs-1:0][p_data_bits-1:0]           req_wdata,
    output logic [$clog2(p_num_regs)-1:0]                    rf_waddr,
    output logic [p_data_bits-1:0]                           rf_wdata,
    output logic                                             rf_wen,
    output logic [$clog2(p_num_reqs)-1:0]                    grant_id
);

    localparam int AW = $clog2(p_num_regs);
    localparam int IW = $clog2(p_num_reqs);

    logic [p_num_reqs-1:0] cand;
    logic [p_num_reqs-1:0] squash;
    logic [p_num_reqs-1:0] gnt;
    logic [IW-1:0]         gnt_idx;
    logic                  gnt_vld;

    always_comb begin
        cand   = '0;
        squash = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (req_waddr[i] == AW'(RF_ZERO_ADDR)) begin
                squash[i] = req_val[i];
            end else begin
                cand[i] = req_val[i];
            end
        end
    end

    rr_arbiter #(
        .p_num_reqs (p_num_reqs)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (cand),
        .en      (rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Nothing is acknowledged while reset is held, including x0 squashes.
    assign req_rdy = rst ? (squash | gnt) : '0;

    logic                   rf_wen_q,   rf_wen_d;
    logic [AW-1:0]          rf_waddr_q, rf_waddr_d;
    logic [p_data_bits-1:0] rf_wdata_q, rf_wdata_d;
    logic [IW-1:0]          grant_id_q, grant_id_d;

    // Address, data and id hold on idle cycles; only the enable drops.
    always_comb begin
        rf_wen_d   = gnt_vld;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        grant_id_d = grant_id_q;
        if (gnt_vld) begin
            rf_waddr_d = req_waddr[gnt_idx];
            rf_wdata_d = req_wdata[gnt_idx];
            grant_id_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= '0;
        end else begin
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign grant_id = grant_id_q;

endmodule
